// File: rtl/stc_pkg.sv
// stc_pkg: shared types and helpers for the stream tolerance checker.
// Holds the checker state encoding and the modular tolerance-window rule.
package stc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMP   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } stc_state_e;

  // Widest component the tolerance rule supports.
  localparam int STC_MAX_DW = 32;

  // Modular window: d = (gold - dut) mod 2^dw must lie within +/-tol of zero.
  // Arithmetic is carried one bit wider so 2^dw itself is representable.
  function automatic logic tol_ok(input logic [STC_MAX_DW-1:0] gold,
                                  input logic [STC_MAX_DW-1:0] dut,
                                  input logic [STC_MAX_DW-1:0] tol,
                                  input int unsigned           dw);
    logic [STC_MAX_DW:0] span;
    logic [STC_MAX_DW:0] d;
    span = (STC_MAX_DW+1)'(1) << dw;
    d    = ({1'b0, gold} - {1'b0, dut}) & (span - (STC_MAX_DW+1)'(1));
    return (d <= {1'b0, tol}) || (d >= span - {1'b0, tol});
  endfunction

endpackage

// File: rtl/stc_if.sv
// stc_if: vector stream handshake plus golden ROM address/data bundle.
// master = stimulus/ROM side, slave = checker side.
interface stc_if #(
  parameter int LANES = 16,
  parameter int LW    = 32,
  parameter int CNT_W = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*LW-1:0]   in_data;
  logic [CNT_W-1:0]      gold_addr;
  logic [LW-1:0]         gold_data;

  modport master (
    output in_valid, in_data, gold_data,
    input  in_ready, gold_addr
  );

  modport slave (
    input  in_valid, in_data, gold_data,
    output in_ready, gold_addr
  );
endinterface

// File: rtl/stc_tol_cmp.sv
// stc_tol_cmp: combinational single-lane tolerance compare.
// A complex lane {real, imag} passes only if both components are in window.
module stc_tol_cmp
  import stc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int CPLX = 1,
  parameter int TOL  = 3
)(
  input  logic [DW*(1+CPLX)-1:0] i_gold,
  input  logic [DW*(1+CPLX)-1:0] i_dut,
  output logic                   o_lane_ok
);

  logic w_lo_ok;

  assign w_lo_ok = tol_ok(STC_MAX_DW'(i_gold[DW-1:0]), STC_MAX_DW'(i_dut[DW-1:0]),
                          STC_MAX_DW'(TOL), DW);

  generate
    if (CPLX != 0) begin : g_cplx
      logic w_hi_ok;
      assign w_hi_ok   = tol_ok(STC_MAX_DW'(i_gold[2*DW-1:DW]), STC_MAX_DW'(i_dut[2*DW-1:DW]),
                                STC_MAX_DW'(TOL), DW);
      assign o_lane_ok = w_hi_ok && w_lo_ok;
    end else begin : g_real
      assign o_lane_ok = w_lo_ok;
    end
  endgenerate

endmodule

// File: rtl/stream_tol_checker.sv
// stream_tol_checker: accepts one vector per handshake, walks its lanes
// serially against a golden ROM, counts out-of-window lanes and reports a
// done/pass/fail verdict. Optional build macro STC_FIRST_ERR_EN adds capture
// of the first mismatching lane; without it the first_err_* outputs read 0.
module stream_tol_checker
  import stc_pkg::*;
#(
  parameter int DW         = 16,
  parameter int LANES      = 16,
  parameter int CPLX       = 1,
  parameter int TOL        = 3,
  parameter int DEPTH      = 1024,
  parameter int FAIL_LIMIT = 48,
  parameter int CNT_W      = 16
)(
  input  logic                   clk,
  input  logic                   rst,
  stc_if.slave                   s_if,
  output logic [CNT_W-1:0]       err_cnt,
  output logic                   fail,
  output logic                   done,
  output logic                   pass,
  output logic                   drop,
  output logic                   first_err_valid,
  output logic [CNT_W-1:0]       first_err_idx,
  output logic [DW*(1+CPLX)-1:0] first_err_dut,
  output logic [DW*(1+CPLX)-1:0] first_err_gold
);

  localparam int LW     = DW*(1+CPLX);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES-1);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(DEPTH-1);
  localparam logic [CNT_W-1:0]  END_IDX   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  FAIL_LIM  = CNT_W'(FAIL_LIMIT);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_CMP   = ST_CMP;
  localparam logic [1:0] S_DONE  = ST_DONE;
  localparam logic [1:0] S_ABORT = ST_ABORT;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]          r_state;
  logic [CNT_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_gold_addr;
  logic [CNT_W-1:0]    r_err;
  logic [LANE_W-1:0]   r_lane;
  logic                r_issue;
  logic                r_fail;
  logic                r_drop;
  logic [LANES*LW-1:0] r_vec;
  logic                r_vld_p1;
  logic                r_last_p1;
  logic [LANE_W-1:0]   r_lane_p1;

  logic [CNT_W-1:0]    w_issue_idx;
  logic                w_issue_last;
  logic [CNT_W-1:0]    w_cmp_idx;
  logic [CNT_W-1:0]    w_cmp_end;
  logic [CNT_W-1:0]    w_err_next;
  logic [LW-1:0]       w_dut_lane;
  logic                w_lane_ok;

  // Issue side: stop at the last lane or at the end of the golden stream.
  assign w_issue_idx  = r_idx + CNT_W'(r_lane);
  assign w_issue_last = (r_lane == LAST_LANE) || (w_issue_idx == LAST_IDX);

  // Compare side: the lane whose address went out on the previous edge.
  assign w_cmp_idx  = r_idx + CNT_W'(r_lane_p1);
  assign w_cmp_end  = w_cmp_idx + CNT_W'(1);
  assign w_dut_lane = r_vec[int'(r_lane_p1)*LW +: LW];
  assign w_err_next = w_lane_ok ? r_err : sat_inc(r_err);

  stc_tol_cmp #(
    .DW   (DW),
    .CPLX (CPLX),
    .TOL  (TOL)
  ) u_cmp (
    .i_gold    (s_if.gold_data),
    .i_dut     (w_dut_lane),
    .o_lane_ok (w_lane_ok)
  );

  // Latch the accepted vector; only meaningful while it is being walked.
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && s_if.in_valid)
      r_vec <= s_if.in_data;
  end

  // Control FSM: accept, issue/compare lanes, then settle to IDLE/DONE/ABORT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_gold_addr <= '0;
      r_err       <= '0;
      r_lane      <= '0;
      r_issue     <= 1'b0;
      r_fail      <= 1'b0;
      r_drop      <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_last_p1   <= 1'b0;
      r_lane_p1   <= '0;
    end else begin
      r_vld_p1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (s_if.in_valid) begin
            r_state <= S_CMP;
            r_lane  <= '0;
            r_issue <= 1'b1;
          end
        end
        S_CMP: begin
          // stage p0 -> p1: address issued, lane tag follows it
          if (r_issue) begin
            r_gold_addr <= w_issue_idx;
            r_vld_p1    <= 1'b1;
            r_lane_p1   <= r_lane;
            r_last_p1   <= w_issue_last;
            r_lane      <= r_lane + LANE_W'(1);
            if (w_issue_last)
              r_issue <= 1'b0;
          end
          // stage p1: ROM data present, compare and account
          if (r_vld_p1) begin
            r_err <= w_err_next;
            if (r_last_p1) begin
              r_idx <= w_cmp_end;
              if (w_err_next >= FAIL_LIM) begin
                r_fail  <= 1'b1;
                r_state <= S_ABORT;
              end else if (w_cmp_end == END_IDX) begin
                r_state <= S_DONE;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: begin
          if (s_if.in_valid)
            r_drop <= 1'b1;
        end
      endcase
    end
  end

  assign s_if.in_ready  = (r_state != S_CMP);
  assign s_if.gold_addr = r_gold_addr;
  assign err_cnt        = r_err;
  assign fail           = r_fail;
  assign done           = (r_state == S_DONE) || (r_state == S_ABORT);
  assign pass           = done && !r_fail && (r_err == '0);
  assign drop           = r_drop;

`ifdef STC_FIRST_ERR_EN
  logic             r_fe_vld;
  logic [CNT_W-1:0] r_fe_idx;
  logic [LW-1:0]    r_fe_dut;
  logic [LW-1:0]    r_fe_gold;

  // Capture the first out-of-window lane seen since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fe_vld  <= 1'b0;
      r_fe_idx  <= '0;
      r_fe_dut  <= '0;
      r_fe_gold <= '0;
    end else if ((r_state == S_CMP) && r_vld_p1 && !w_lane_ok && !r_fe_vld) begin
      r_fe_vld  <= 1'b1;
      r_fe_idx  <= w_cmp_idx;
      r_fe_dut  <= w_dut_lane;
      r_fe_gold <= s_if.gold_data;
    end
  end

  assign first_err_valid = r_fe_vld;
  assign first_err_idx   = r_fe_idx;
  assign first_err_dut   = r_fe_dut;
  assign first_err_gold  = r_fe_gold;
`else
  assign first_err_valid = 1'b0;
  assign first_err_idx   = '0;
  assign first_err_dut   = '0;
  assign first_err_gold  = '0;
`endif

endmodule
